// File: rtl/lcd_cmd_host_if.sv
// ---------------------------------------------------------------------------
// lcd_cmd_host_if
//   Handshake bundle around the LCD command host.
//   Upstream side : in_cmd / in_valid in, in_ready out.
//   Controller side: cmd / cmd_valid out, busy / done in.
//   Modports:
//     slave  - the host itself (lcd_cmd_host)
//     master - whatever drives the producer and models the controller
// ---------------------------------------------------------------------------
interface lcd_cmd_host_if;
    logic [3:0] in_cmd;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;

    modport slave (
        input  in_cmd, in_valid, busy, done,
        output in_ready, cmd, cmd_valid
    );

    modport master (
        output in_cmd, in_valid, busy, done,
        input  in_ready, cmd, cmd_valid
    );
endinterface

// File: rtl/lcd_cmd_host.sv
// ---------------------------------------------------------------------------
// lcd_cmd_host
//   Buffers upstream LCD controller opcodes in a small FIFO and strobes them
//   one at a time to the controller, only while the controller is not busy.
//   After a WRITE (opcode 0) is accepted nothing more is taken; once that
//   WRITE is strobed and the controller reports done, the host parks in a
//   terminal FINISH state.
//
//   Ports:
//     clk, reset     rising-edge clock, asynchronous active-high reset
//     bus (slave)    in_cmd/in_valid/in_ready upstream,
//                    cmd/cmd_valid/busy/done towards the controller
//     issued_cnt     strobes since reset, saturating at 255
//     skipped_cnt    shifts dropped by the shadow filter, saturating at 255
//     finished       sticky, set when done is seen after a strobed WRITE
//
//   Build option:
//     LCD_HOST_SHADOW_EN  track a shadow operation point (x,y) in 0..6 and
//                         drop shifts that would leave that range instead of
//                         strobing them. Undefined: every command is strobed
//                         and skipped_cnt is 0.
// ---------------------------------------------------------------------------
module lcd_cmd_host #(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    lcd_cmd_host_if.slave bus,
    output logic [7:0]    issued_cnt,
    output logic [7:0]    skipped_cnt,
    output logic          finished
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [3:0] OP_WRITE = 4'd0;
    localparam logic [3:0] OP_UP    = 4'd1;
    localparam logic [3:0] OP_DOWN  = 4'd2;
    localparam logic [3:0] OP_LEFT  = 4'd3;
    localparam logic [3:0] OP_RIGHT = 4'd4;

    typedef enum logic [2:0] {
        IDLE, ISSUE, GUARD, WAIT, DONE_WAIT, FINISH
    } state_t;

    state_t        state;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          wr_queued;
    logic [3:0]    cmd_q;
    logic          cmd_valid_q;

    logic       empty, full, in_ready, push, pop;
    logic       head_skip, skip_now, can_issue;
    logic [3:0] head;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign head      = mem[rd_ptr];
    assign in_ready  = !full && !wr_queued && (state != FINISH);
    assign push      = bus.in_valid && in_ready;
    assign can_issue = !empty && !bus.busy && !head_skip;
    // An out-of-range shift at the head is dropped in IDLE regardless of busy.
    assign skip_now  = (state == IDLE) && !empty && head_skip;
    assign pop       = (state == ISSUE) || skip_now;

    assign bus.in_ready  = in_ready;
    assign bus.cmd       = cmd_q;
    assign bus.cmd_valid = cmd_valid_q;

    // ---------------- command FIFO ----------------
    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_cmd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            wr_queued <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (bus.in_cmd == OP_WRITE) wr_queued <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // ---------------- issue FSM ----------------
    // cmd_valid is high exactly while in ISSUE. WAIT with busy already low
    // goes straight back to ISSUE when a command is ready, which gives the
    // 3-cycle minimum strobe spacing (ISSUE, GUARD, WAIT).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            issued_cnt  <= '0;
            finished    <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_issue) begin
                        state       <= ISSUE;
                        cmd_q       <= head;
                        cmd_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= GUARD;
                    if (issued_cnt != 8'hFF) issued_cnt <= issued_cnt + 8'd1;
                end
                // Controller raises busy a cycle after sampling, so busy is
                // meaningless here.
                GUARD: state <= (cmd_q == OP_WRITE) ? DONE_WAIT : WAIT;
                WAIT: begin
                    if (!bus.busy) begin
                        if (can_issue) begin
                            state       <= ISSUE;
                            cmd_q       <= head;
                            cmd_valid_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE_WAIT: begin
                    if (bus.done) begin
                        state    <= FINISH;
                        finished <= 1'b1;
                    end
                end
                FINISH:  ;
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- shadow point filter ----------------
`ifdef LCD_HOST_SHADOW_EN
    logic [2:0] sh_x, sh_y;

    always_comb begin
        head_skip = 1'b0;
        case (head)
            OP_UP:    head_skip = (sh_y == 3'd0);
            OP_DOWN:  head_skip = (sh_y == 3'd6);
            OP_LEFT:  head_skip = (sh_x == 3'd0);
            OP_RIGHT: head_skip = (sh_x == 3'd6);
            default:  head_skip = 1'b0;
        endcase
    end

    // Only in-range shifts are ever strobed, so the update cannot overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_x        <= 3'd3;
            sh_y        <= 3'd3;
            skipped_cnt <= '0;
        end else begin
            if (state == ISSUE) begin
                case (cmd_q)
                    OP_UP:    sh_y <= sh_y - 3'd1;
                    OP_DOWN:  sh_y <= sh_y + 3'd1;
                    OP_LEFT:  sh_x <= sh_x - 3'd1;
                    OP_RIGHT: sh_x <= sh_x + 3'd1;
                    default:  ;
                endcase
            end
            if (skip_now && skipped_cnt != 8'hFF)
                skipped_cnt <= skipped_cnt + 8'd1;
        end
    end
`else
    assign head_skip   = 1'b0;
    assign skipped_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lcd_cmd_host.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_host
//   Self-checking bench for lcd_cmd_host: a cycle table for the main
//   handshake timeline, hand-written corner sequences (full FIFO, shadow
//   skips, reset mid-operation) and a randomized run scored against an
//   in-order reference of accepted commands.
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_host;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] issued_cnt, skipped_cnt;
    logic       finished;

    always #5 clk = ~clk;

    lcd_cmd_host_if bus ();

    lcd_cmd_host #(.DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .issued_cnt  (issued_cnt),
        .skipped_cnt (skipped_cnt),
        .finished    (finished)
    );

`ifdef LCD_HOST_SHADOW_EN
    localparam int SH_STROBES = 3;
    localparam int SH_SKIPS   = 1;
`else
    localparam int SH_STROBES = 4;
    localparam int SH_SKIPS   = 0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
    } strobe_t;

    strobe_t strobes[$];
    logic    prev_busy;
    int      last_strobe = -100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records every strobe, checks busy was low on the
    // deciding edge and that strobes are at least 3 cycles apart.
    always @(negedge clk) begin
        if (reset) begin
            last_strobe <= -100;
        end else if (bus.cmd_valid) begin
            chk("busy_low_before_strobe", prev_busy, 0);
            chk("strobe_spacing_ge3", (cyc - last_strobe) >= 3, 1);
            strobes.push_back('{cyc: cyc, cmd: bus.cmd});
            last_strobe <= cyc;
        end
        prev_busy <= bus.busy;
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic b);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_cmd   = 4'd0;
        bus.busy     = b;
        bus.done     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push(input logic [3:0] c);
        bus.in_valid = 1'b1;
        bus.in_cmd   = c;
        next();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string name);
        int k = 0;
        while (strobes.size() < n && k < budget) begin
            next();
            k++;
        end
        chk(name, strobes.size(), n);
    endtask

    // ---------------- reference model for the random run ----------------
    logic [3:0] exp_q[$];
    int         mx, my, exp_skips;

    task automatic model_accept(input logic [3:0] c);
`ifdef LCD_HOST_SHADOW_EN
        bit skip = 1'b0;
        case (c)
            4'd1: if (my == 0) skip = 1'b1; else my--;
            4'd2: if (my == 6) skip = 1'b1; else my++;
            4'd3: if (mx == 0) skip = 1'b1; else mx--;
            4'd4: if (mx == 6) skip = 1'b1; else mx++;
            default: ;
        endcase
        if (skip) exp_skips++;
        else      exp_q.push_back(c);
`else
        exp_q.push_back(c);
`endif
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic       v;
        logic [3:0] c;
        logic       busy;
        logic       done;
        logic       e_cv;
        logic [3:0] e_cmd;
        logic       e_rdy;
        logic [7:0] e_iss;
        logic       e_fin;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // v c busy done | cv cmd rdy iss fin
        tbl[0]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 5, 1, 0, 0, 0, 1, 0, 0};  // push MAX while busy
        tbl[2]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};  // busy falls
        tbl[5]  = '{0, 0, 0, 0, 1, 5, 1, 0, 0};  // strobe MAX
        tbl[6]  = '{0, 0, 1, 0, 0, 5, 1, 1, 0};  // guard
        tbl[7]  = '{1, 7, 1, 0, 0, 5, 1, 1, 0};  // push AVERAGE
        tbl[8]  = '{1, 0, 1, 0, 0, 5, 1, 1, 0};  // push WRITE
        tbl[9]  = '{1, 3, 1, 0, 0, 5, 0, 1, 0};  // refused after WRITE
        tbl[10] = '{0, 0, 0, 0, 0, 5, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 7, 0, 1, 0};
        tbl[12] = '{0, 0, 1, 0, 0, 7, 0, 2, 0};  // busy glitch in guard
        tbl[13] = '{0, 0, 0, 0, 0, 7, 0, 2, 0};
        tbl[14] = '{0, 0, 0, 0, 1, 0, 0, 2, 0};  // strobe WRITE, 3 cycles later
        tbl[15] = '{0, 0, 0, 1, 0, 0, 0, 3, 0};  // done in guard is ignored
        tbl[16] = '{0, 0, 1, 0, 0, 0, 0, 3, 0};
        tbl[17] = '{0, 0, 1, 0, 0, 0, 0, 3, 0};
        tbl[18] = '{0, 0, 0, 1, 0, 0, 0, 3, 0};  // done -> FINISH
        tbl[19] = '{1, 2, 0, 0, 0, 0, 0, 3, 1};
        tbl[20] = '{1, 2, 0, 1, 0, 0, 0, 3, 1};
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_cmd   = 4'd0;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;

        // Reset values
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd", bus.cmd, 0);
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_issued", issued_cnt, 0);
        chk("rst_skipped", skipped_cnt, 0);
        chk("rst_finished", finished, 0);

        // Table: MAX after busy, then AVERAGE + WRITE through to FINISH
        reset_dut(1'b1);
        strobes.delete();
        for (int i = 0; i < 21; i++) begin
            bus.in_valid = tbl[i].v;
            bus.in_cmd   = tbl[i].c;
            bus.busy     = tbl[i].busy;
            bus.done     = tbl[i].done;
            @(negedge clk);
            chk($sformatf("tbl%0d_cmd_valid", i), bus.cmd_valid, tbl[i].e_cv);
            chk($sformatf("tbl%0d_cmd", i), bus.cmd, tbl[i].e_cmd);
            chk($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_issued", i), issued_cnt, tbl[i].e_iss);
            chk($sformatf("tbl%0d_finished", i), finished, tbl[i].e_fin);
            next();
        end
        bus.in_valid = 1'b0;
        bus.done     = 1'b0;
        repeat (8) next();
        chk("finish_no_more_strobes", strobes.size(), 3);

        // Reset out of FINISH clears the sticky flag and reopens the input
        reset = 1'b1;
        #1;
        chk("finish_rst_finished", finished, 0);
        chk("finish_rst_in_ready", bus.in_ready, 1);

        // Full FIFO: 8 pushes while busy, 9th refused, all 8 strobed in order
        reset_dut(1'b1);
        strobes.delete();
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_cmd   = 4'(5 + i);
            @(negedge clk);
            chk($sformatf("fill%0d_in_ready", i), bus.in_ready, 1);
            next();
        end
        bus.in_valid = 1'b1;
        bus.in_cmd   = 4'd13;
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 0);
        next();
        bus.in_valid = 1'b0;
        bus.busy     = 1'b0;
        wait_strobes(8, 60, "full_drain_count");
        repeat (10) next();
        chk("full_total_strobes", strobes.size(), 8);
        for (int i = 0; i < strobes.size() && i < 8; i++) begin
            chk($sformatf("full_order%0d", i), strobes[i].cmd, 5 + i);
            if (i > 0)
                chk($sformatf("full_spacing%0d", i), strobes[i].cyc - strobes[i-1].cyc, 3);
        end
        chk("full_issued", issued_cnt, 8);

        // Shifts up x4 from (3,3) with busy low
        reset_dut(1'b0);
        strobes.delete();
        for (int i = 0; i < 4; i++) push(4'd1);
        wait_strobes(SH_STROBES, 60, "shift_strobe_count");
        repeat (15) next();
        chk("shift_total_strobes", strobes.size(), SH_STROBES);
        chk("shift_skipped", skipped_cnt, SH_SKIPS);
        chk("shift_issued", issued_cnt, SH_STROBES);
        if (strobes.size() >= 2)
            chk("shift_spacing", strobes[1].cyc - strobes[0].cyc, 3);
        else
            chk("shift_spacing_strobes", strobes.size(), 2);

        // Reset during GUARD with 3 commands still queued
        reset_dut(1'b1);
        strobes.delete();
        for (int i = 0; i < 4; i++) push(4'd9);
        bus.busy = 1'b0;
        begin
            int k = 0;
            @(negedge clk);
            while (!bus.cmd_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("guard_strobe_seen", bus.cmd_valid, 1);
        end
        next();  // now in GUARD
        reset = 1'b1;
        #1;
        chk("guard_rst_cmd_valid", bus.cmd_valid, 0);
        chk("guard_rst_issued", issued_cnt, 0);
        chk("guard_rst_in_ready", bus.in_ready, 1);
        chk("guard_rst_cmd", bus.cmd, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        strobes.delete();
        repeat (12) next();
        chk("guard_flushed_no_strobe", strobes.size(), 0);
        push(4'd6);
        wait_strobes(1, 10, "guard_new_push_strobe");
        if (strobes.size() > 0) chk("guard_new_push_cmd", strobes[0].cmd, 6);
        next();
        chk("guard_new_push_issued", issued_cnt, 1);

        // Randomized run against the in-order reference
        reset_dut(1'b0);
        strobes.delete();
        exp_q.delete();
        mx = 3;
        my = 3;
        exp_skips = 0;
        for (int i = 0; i < 900; i++) begin
            bus.in_valid = ($urandom_range(0, 99) < 50);
            bus.in_cmd   = 4'($urandom_range(1, 15));
            bus.busy     = ($urandom_range(0, 99) < 35);
            bus.done     = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) model_accept(bus.in_cmd);
            next();
        end
        bus.in_valid = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        wait_strobes(exp_q.size(), 100, "rand_drain_count");
        repeat (10) next();
        chk("rand_total_strobes", strobes.size(), exp_q.size());
        for (int i = 0; i < strobes.size() && i < exp_q.size(); i++)
            chk($sformatf("rand_order%0d", i), strobes[i].cmd, exp_q[i]);
        chk("rand_issued", issued_cnt, (exp_q.size() > 255) ? 255 : exp_q.size());
        chk("rand_skipped", skipped_cnt, (exp_skips > 255) ? 255 : exp_skips);
        chk("rand_in_ready_idle", bus.in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_cmd_host.md
# lcd_cmd_host

Command-issuing host for the LCD image controller: buffers a command stream from an upstream producer, presents one command at a time on the controller's `cmd`/`cmd_valid` port only while `busy` is low, and tracks completion through `busy` and `done`. It sits between the testbench or system sequencer and the LCD controller. It is the initiator side of the controller's command handshake.

## Interface
- `DEPTH`, 8: command FIFO depth; power of two, 2..16.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high.
- `in_cmd` input 4: upstream command opcode, 0..11.
- `in_valid` input 1: upstream command present.
- `in_ready` output 1: host accepts `in_cmd` this cycle.
- `cmd` output 4: opcode to the controller. Registered.
- `cmd_valid` output 1: one-cycle command strobe. Registered.
- `busy` input 1: controller busy. No command may be strobed while it is high.
- `done` input 1: controller finished writing IRAM.
- `issued_cnt` output 8: commands strobed since reset. Saturates at 255.
- `skipped_cnt` output 8: commands discarded by the shadow filter. Saturates at 255.
- `finished` output 1: sticky. High once `done` is seen after a WRITE.

## Operation
- **Opcodes:**
  - 0 WRITE
  - 1-4 shift up/down/left/right
  - 5 MAX, 6 MIN, 7 AVERAGE
  - 8 CCW rotate, 9 CW rotate
  - 10 mirror X, 11 mirror Y
  - Opcodes 12..15 are accepted and forwarded unchanged.
- **FIFO push:**
  - A push occurs when `in_valid && in_ready`.
  - `in_ready = !full && !wr_queued && state != FINISH`.
  - `wr_queued` is set when WRITE is pushed and is cleared only by reset. Nothing is accepted after a WRITE.
- **FIFO pop:** only in ISSUE, or during a shadow skip.
- **Push and pop in the same cycle:** allowed. Occupancy is unchanged.
- **Pop priority:** when not full, a pop never blocks a push.
- **FSM states:**
  - IDLE → ISSUE: when FIFO is non-empty, `busy == 0`, and the head is not skipped.
  - ISSUE: `cmd_valid = 1`, `cmd = head`, pop the FIFO, increment `issued_cnt`. Always → GUARD.
  - GUARD: one cycle; `busy` is ignored, because the controller raises `busy` one cycle after sampling. Next state is DONE_WAIT if the issued opcode was WRITE, otherwise WAIT.
  - WAIT → IDLE: when `busy == 0`.
  - DONE_WAIT → FINISH: when `done == 1`.
  - FINISH: terminal. `finished = 1`.
- **`done` while not in DONE_WAIT:** ignored.
- **`busy` high at reset release** (image still loading): IDLE holds until `busy` falls.
- **Counters:** 8-bit, stick at 255.

## Timing
- **Reset values:**
  - `cmd = 0`, `cmd_valid = 0`, `in_ready = 1`
  - `issued_cnt = 0`, `skipped_cnt = 0`, `finished = 0`
  - FIFO empty, `wr_queued = 0`, state IDLE
  - shadow point (3,3)
- **Push-to-strobe latency:** with the FIFO empty, state IDLE and `busy` low, a push at edge N gives `cmd_valid` high for the cycle after edge N+1.
- **`cmd_valid` width:** exactly one cycle. `cmd` holds its value until the next strobe.
- **Minimum strobe spacing:** 3 cycles (ISSUE, GUARD, WAIT with `busy` already low).
- **`busy` glitch during GUARD:** no effect.
- **Reset asserted mid-operation:**
  - All state returns to reset values on the same edge.
  - A strobe in flight is truncated.
  - The FIFO is flushed.

## Configuration
- **`LCD_HOST_SHADOW_EN` defined:**
  - The host keeps a shadow operation point (x,y), each in 0..6, starting at (3,3).
  - It is updated on each strobed shift: up y−1, down y+1, left x−1, right x+1.
  - A head shift that would leave 0..6 is a no-op. In IDLE, such a head is popped without a strobe and `skipped_cnt` is incremented.
  - A skip takes one cycle, is independent of `busy`, and leaves the state in IDLE.
- **`LCD_HOST_SHADOW_EN` undefined:**
  - Every command is strobed.
  - `skipped_cnt` is tied to 0.
  - No shadow registers exist.

## Test plan
- Reset with `busy = 1` for 20 cycles, push 5 (MAX) → no strobe while `busy` is high. A single strobe with `cmd = 5` follows 1 cycle after `busy` falls. `issued_cnt = 1`.
- Push 8 commands back-to-back with `busy` high → `in_ready` falls after the 8th, a 9th push is refused, and all 8 are strobed in order.
- Push 7 then 0, model `busy` high 2 cycles after WRITE, then pulse `done` → 2 strobes, FINISH reached, `finished = 1`, `in_ready = 0`, and further `in_valid` is ignored.
- Push 3 while `busy` stays low (shift, controller never raises `busy`) → next strobe spacing is exactly 3 cycles.
- With `LCD_HOST_SHADOW_EN` defined, push 1,1,1,1 → 3 strobes, `skipped_cnt = 1`, shadow y = 0. Without the macro → 4 strobes, `skipped_cnt = 0`.
- Assert `reset` during GUARD with 3 commands queued → `cmd_valid` low immediately, FIFO empty, counters 0, and no strobe after release until a new push.
